// File: rtl/cla_16bit_if.sv
// cla_16bit_if: operand and result bundle for the 16-bit carry-lookahead adder.
interface cla_16bit_if;
    logic [15:0] A;
    logic [15:0] B;
    logic        c0;
    logic [15:0] sum;
    logic        Cout;
    logic        PG;
    logic        GG;
    modport master (output A, B, c0, input sum, Cout, PG, GG);
    modport slave  (input A, B, c0, output sum, Cout, PG, GG);
endinterface

// File: rtl/cla_16bit.sv
// cla_16bit: two-level carry-lookahead adder, four 4-bit blocks, registered outputs.
module cla_16bit (
    input logic        clk,
    input logic        rst,
    cla_16bit_if.slave bus
);
    logic [15:0] w_p, w_g, w_c;
    logic [3:0]  w_bp, w_bg;
    logic [4:0]  w_cb;
    logic        w_pg, w_gg;
    logic [15:0] r_sum;
    logic        r_cout, r_pg, r_gg;
    assign w_p = bus.A ^ bus.B;
    assign w_g = bus.A & bus.B;
    for (genvar k = 0; k < 4; k++) begin : g_blk
        logic [3:0] w_lp, w_lg;
        logic       w_ci;
        assign w_lp = w_p[4*k +: 4];
        assign w_lg = w_g[4*k +: 4];
        assign w_ci = w_cb[k];
        assign w_bp[k] = &w_lp;
        assign w_bg[k] = w_lg[3] | (w_lp[3] & w_lg[2]) | (w_lp[3] & w_lp[2] & w_lg[1])
                       | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);
        assign w_c[4*k]   = w_ci;
        assign w_c[4*k+1] = w_lg[0] | (w_lp[0] & w_ci);
        assign w_c[4*k+2] = w_lg[1] | (w_lp[1] & w_lg[0]) | (w_lp[1] & w_lp[0] & w_ci);
        assign w_c[4*k+3] = w_lg[2] | (w_lp[2] & w_lg[1]) | (w_lp[2] & w_lp[1] & w_lg[0])
                          | (w_lp[2] & w_lp[1] & w_lp[0] & w_ci);
    end
    // Second level: every block carry-in is a flat sum of products, no inter-block ripple.
    assign w_cb[0] = bus.c0;
    assign w_cb[1] = w_bg[0] | (w_bp[0] & bus.c0);
    assign w_cb[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & bus.c0);
    assign w_cb[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                   | (w_bp[2] & w_bp[1] & w_bp[0] & bus.c0);
    assign w_cb[4] = w_gg | (w_pg & bus.c0);
    assign w_pg = &w_bp;
    assign w_gg = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
                | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_pg   <= 1'b0;
            r_gg   <= 1'b0;
        end else begin
            r_sum  <= w_p ^ w_c;
            r_cout <= w_cb[4];
            r_pg   <= w_pg;
            r_gg   <= w_gg;
        end
    end
    assign bus.sum  = r_sum;
    assign bus.Cout = r_cout;
    assign bus.PG   = r_pg;
    assign bus.GG   = r_gg;
endmodule

// File: tb/tb_cla_16bit.sv
// tb_cla_16bit: directed and random checks of the registered 16-bit CLA adder.
module tb_cla_16bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    cla_16bit_if bus ();
    cla_16bit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Observed/expected packing: {Cout, PG, GG, sum}.
    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got Cout=%b PG=%b GG=%b sum=%h, want Cout=%b PG=%b GG=%b sum=%h",
                     tag, obs[18], obs[17], obs[16], obs[15:0], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s, g;
        s = {1'b0, a} + {1'b0, b} + {16'b0, c};
        g = {1'b0, a} + {1'b0, b};
        return {s[16], &(a ^ b), g[16], s[15:0]};
    endfunction
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c);
        bus.A = a;
        bus.B = b;
        bus.c0 = c;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [18:0] obs();
        return {bus.Cout, bus.PG, bus.GG, bus.sum};
    endfunction
    initial begin
        logic [15:0] a, b;
        logic        c;
        rst = 1'b1;
        step(16'hABCD, 16'h1234, 1'b1);
        check("reset", obs(), 19'h0);
        rst = 1'b0;
        step(16'h02EB, 16'h5555, 1'b0);
        check("v029", obs(), {3'b000, 16'h5840});
        step(16'hFFFF, 16'h0000, 1'b1);
        check("ffff_0_c1", obs(), {3'b110, 16'h0000});
        step(16'hFFFF, 16'h0000, 1'b0);
        check("ffff_0_c0", obs(), {3'b010, 16'hFFFF});
        step(16'hFFFF, 16'hFFFF, 1'b0);
        check("ffff_ffff", obs(), {3'b101, 16'hFFFE});
        step(16'h8000, 16'h8000, 1'b1);
        check("8000_8000_c1", obs(), {3'b101, 16'h0001});
        step(16'h0000, 16'h0000, 1'b0);
        check("zero", obs(), {3'b000, 16'h0000});
        step(16'h0F0F, 16'hF0F0, 1'b1);
        check("pg_c1", obs(), {3'b110, 16'h0000});
        step(16'h00FF, 16'h0001, 1'b0);
        check("mid_carry", obs(), {3'b000, 16'h0100});
        step(16'h1234, 16'h4321, 1'b0);
        check("pre_reset", obs(), {3'b000, 16'h5555});
        rst = 1'b1;
        step(16'hFFFF, 16'hFFFF, 1'b1);
        check("mid_reset", obs(), 19'h0);
        rst = 1'b0;
        step(16'h0001, 16'h0001, 1'b0);
        check("post_reset", obs(), {3'b000, 16'h0002});
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            step(a, b, c);
            check("random", obs(), model(a, b, c));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
